addsub_serial_nbit: RTL and testbench
=====================================

Name: addsub_serial_nbit

Overview:
Multi-cycle, slice-serial add/subtract unit for the calculator datapath. It is the parametrised successor to the combinational n-bit subtractor. Operands of N bits are processed K bits per clock, LSB slice first, with the carry/borrow passed between slices in a register. Handshake is start/busy/done, and the unit produces carry/borrow, signed-overflow and zero flags.

Parameters:
N, 16, operand/result width in bits; must be an integer multiple of K.
K, 4, slice width processed per clock; 1 <= K <= N.
S, N/K, derived slice count; local, not overridable.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled on rising clk edge when unit is not busy.
op  input  1  0 = add (a + b + ci); 1 = subtract (a - b - ci).
a  input  N  operand A, captured on accepted start.
b  input  N  operand B, captured on accepted start.
ci  input  1  carry-in (add) or borrow-in (sub), captured on accepted start.
busy  output  1  high while slices are being processed.
done  output  1  one-cycle pulse; result and flags valid.
result  output  N  sum or difference, modulo 2^N.
co  output  1  carry-out (add) or borrow-out (sub) of the MSB slice.
ovf  output  1  two's-complement signed overflow.
zero  output  1  high when result == 0.

Behaviour:
- Reset (async, any time, including mid-operation):
  - State goes to IDLE.
  - busy, done, result, co, ovf and zero all go to 0.
  - Internal operand, slice-index and carry registers clear.
  - An operation in progress is aborted. No done is produced for it.
- States:
  - IDLE: busy=0, done=0.
    - start=1 captures a, b, op and ci into internal registers, sets slice index i=0 and sets carry reg = ci.
    - Next state is RUN.
  - RUN: busy=1.
    - Each clock computes slice i over bits [i*K +: K].
      - Add: {c, r} = a_s + b_s + c.
      - Sub: {bw, r} = a_s - b_s - bw, where bw=1 means borrow.
    - The result slice is written into the result register. The carry/borrow reg is updated. i increments.
    - After slice S-1 is written, next state is DONE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - co = final carry/borrow.
    - ovf for add: a[N-1]==b[N-1] and result[N-1]!=a[N-1].
    - ovf for sub: a[N-1]!=b[N-1] and result[N-1]!=a[N-1].
    - zero = (result==0).
    - start=1 in DONE is accepted (back-to-back). Next state is RUN with new operands. Otherwise next state is IDLE.
- Latency: if start is accepted at edge t, slices are processed on edges t+1 .. t+S. done is high in the cycle following edge t+S+1 (i.e. it asserts at t+S+1). Throughput is one operation per S+1 cycles.
- result, co, ovf and zero hold their last values from DONE until the next accepted start.
  - During RUN, result is partially updated and not valid. Flags hold their previous values until DONE.
- start while busy=1 is ignored. It is not queued.
- Input changes on a, b, op or ci after capture have no effect on the operation in flight.
- K == N (S=1): one RUN cycle, then DONE. Arithmetic is identical.
- Arithmetic is unsigned modulo 2^N. The co/ovf semantics above hold for all operand values, including a == b and ci=1.

Test Plan:
1. N=16, K=4, op=1, a=0x0001, b=0x0002, ci=0 -> result=0xFFFF, co=1, ovf=0, zero=0. done asserts exactly 5 edges after the accepting edge. busy is high for 4 cycles.
2. op=1, a=0x8000, b=0x0001, ci=0 -> result=0x7FFF, co=0, ovf=1. Then op=1, a=0xFFFF, b=0xFFFF, ci=1 -> result=0xFFFF, co=1, ovf=0.
3. op=0, a=0xFFFF, b=0x0001, ci=0 -> result=0x0000, co=1, zero=1, ovf=0. Then op=0, a=0x7FFF, b=0x0001 -> result=0x8000, ovf=1, co=0.
4. Handshake:
   - Start pulsed during RUN with different operands -> ignored; the first result is unchanged.
   - Start held high during DONE -> second operation begins with no IDLE cycle. Its done occurs 5 cycles after the first done.
5. Reset: assert rst two cycles into RUN -> all outputs 0 immediately (asynchronously), with no done pulse. After release, a fresh op=1, a=0x0009, b=0x0006 completes -> result=0x0003.
6. Parameter sweep:
   - N=4, K=4 with the nibble vectors 1-2, 9-6, 5-11, 15-1, 15-15 (op=1, ci=0) -> results 0xF, 0x3, 0xA, 0xE, 0x0 with co = 1, 0, 1, 0, 0.
   - The same vectors with N=8, K=2 (zero-extended) -> results match a reference model, and done latency = 5 cycles.

Source files
------------

// File: rtl/addsub_serial_nbit.sv
// Slice-serial N-bit add/subtract: K bits per clock, LSB slice first, with the
// carry/borrow held in a register between slices. start/busy/done handshake.
module addsub_serial_nbit #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         co,
  output logic         ovf,
  output logic         zero
);

  localparam int S  = N / K;
  localparam int IW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

  state_t        state;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic          op_r;
  logic          c_r;
  logic [IW-1:0] idx;

  logic [K-1:0]  a_s;
  logic [K-1:0]  b_s;
  logic [K:0]    sum;
  logic          ovf_n;
  logic          accept;

  // Bit K of the (K+1)-bit slice sum is the carry for add and the borrow for sub.
  always_comb begin
    a_s = a_r[int'(idx)*K +: K];
    b_s = b_r[int'(idx)*K +: K];
    if (op_r)
      sum = {1'b0, a_s} - {1'b0, b_s} - {{K{1'b0}}, c_r};
    else
      sum = {1'b0, a_s} + {1'b0, b_s} + {{K{1'b0}}, c_r};
  end

  always_comb begin
    if (op_r)
      ovf_n = (a_r[N-1] != b_r[N-1]) && (result[N-1] != a_r[N-1]);
    else
      ovf_n = (a_r[N-1] == b_r[N-1]) && (result[N-1] != a_r[N-1]);
  end

  // A new request is taken in IDLE and also in the FIN cycle (back-to-back).
  assign accept = start && (state != ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= 1'b0;
      c_r    <= 1'b0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      co     <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: ;
        ST_RUN: begin
          result[int'(idx)*K +: K] <= sum[K-1:0];
          c_r <= sum[K];
          if (idx == IW'(S - 1)) begin
            idx   <= '0;
            busy  <= 1'b0;
            state <= ST_FIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_FIN: begin
          done  <= 1'b1;
          co    <= c_r;
          ovf   <= ovf_n;
          zero  <= (result == '0);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (accept) begin
        a_r   <= a;
        b_r   <= b;
        op_r  <= op;
        c_r   <= ci;
        idx   <= '0;
        busy  <= 1'b1;
        state <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_addsub_serial_nbit.sv
// Scoreboard bench for addsub_serial_nbit: three instances (16/4, 4/4, 8/2)
// share the operand buses; expected results are queued at start and checked at done.
module tb_addsub_serial_nbit;

  typedef struct {
    int          id;
    logic [15:0] r;
    logic        co;
    logic        ovf;
    logic        zero;
    int          due;
  } exp_t;

  localparam int NW [3] = '{16, 4, 8};
  localparam int SL [3] = '{4, 1, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [2:0]  co;
  logic [2:0]  ovf;
  logic [2:0]  zero;
  logic [15:0] res16;
  logic [3:0]  res4;
  logic [7:0]  res8;

  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   last_done = 0;
  int   prev_done = 0;
  exp_t sbq [$];

  addsub_serial_nbit #(.N(16), .K(4)) u16 (
    .clk(clk), .rst(rst), .start(start[0]), .op(op), .a(a), .b(b), .ci(ci),
    .busy(busy[0]), .done(done[0]), .result(res16), .co(co[0]), .ovf(ovf[0]), .zero(zero[0])
  );
  addsub_serial_nbit #(.N(4), .K(4)) u4 (
    .clk(clk), .rst(rst), .start(start[1]), .op(op), .a(a[3:0]), .b(b[3:0]), .ci(ci),
    .busy(busy[1]), .done(done[1]), .result(res4), .co(co[1]), .ovf(ovf[1]), .zero(zero[1])
  );
  addsub_serial_nbit #(.N(8), .K(2)) u8 (
    .clk(clk), .rst(rst), .start(start[2]), .op(op), .a(a[7:0]), .b(b[7:0]), .ci(ci),
    .busy(busy[2]), .done(done[2]), .result(res8), .co(co[2]), .ovf(ovf[2]), .zero(zero[2])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] res_of(input int id);
    case (id)
      0:       return res16;
      1:       return {12'h0, res4};
      default: return {8'h0, res8};
    endcase
  endfunction

  function automatic exp_t model(input int id, input bit o, input logic [15:0] x,
                                 input logic [15:0] y, input bit c, input int due);
    exp_t e;
    int n    = NW[id];
    int mask = (1 << n) - 1;
    int xv   = int'(x) & mask;
    int yv   = int'(y) & mask;
    int full;
    bit sx, sy, sr;
    if (!o) begin
      full = xv + yv + int'(c);
      e.co = ((full >> n) & 1) != 0;
    end else begin
      full = xv - yv - int'(c);
      e.co = (full < 0);
    end
    e.r  = 16'(full & mask);
    sx   = ((xv >> (n - 1)) & 1) != 0;
    sy   = ((yv >> (n - 1)) & 1) != 0;
    sr   = ((int'(e.r) >> (n - 1)) & 1) != 0;
    e.ovf  = o ? ((sx != sy) && (sr != sx)) : ((sx == sy) && (sr != sx));
    e.zero = (e.r == 16'h0);
    e.id   = id;
    e.due  = due;
    return e;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i]) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'(i), 32'hFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("dut_id", 32'(i), 32'(e.id));
          chk("result", 32'(res_of(i)), 32'(e.r));
          chk("co", 32'(co[i]), 32'(e.co));
          chk("ovf", 32'(ovf[i]), 32'(e.ovf));
          chk("zero", 32'(zero[i]), 32'(e.zero));
          chk("latency", 32'(cyc), 32'(e.due));
        end
        prev_done = last_done;
        last_done = cyc;
      end
    end
  end

  task automatic go(input int id, input bit o, input logic [15:0] x,
                    input logic [15:0] y, input bit c);
    @(negedge clk);
    op = o; a = x; b = y; ci = c;
    start[id] = 1'b1;
    sbq.push_back(model(id, o, x, y, c, cyc + 1 + SL[id] + 1));
    @(negedge clk);
    start[id] = 1'b0;
  endtask

  task automatic wait_done(input int id, output int nb);
    bit seen = 1'b0;
    nb = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (busy[id]) nb++;
      if (done[id]) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  logic [15:0] sv_a [5] = '{16'd1, 16'd9, 16'd5, 16'd15, 16'd15};
  logic [15:0] sv_b [5] = '{16'd2, 16'd6, 16'd11, 16'd1, 16'd15};

  initial begin
    int nb;
    bit ok;
    rst = 1'b1; start = '0; op = 1'b0; a = '0; b = '0; ci = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_result", 32'(res16), 32'h0);
    chk("reset_ctrl_flags", {27'h0, busy[0], done[0], co[0], ovf[0], zero[0]}, 32'h0);
    rst = 1'b0;

    go(0, 1'b1, 16'h0001, 16'h0002, 1'b0); wait_done(0, nb); chk("busy_cycles", 32'(nb), 32'd4);
    go(0, 1'b1, 16'h8000, 16'h0001, 1'b0); wait_done(0, nb);
    go(0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1); wait_done(0, nb);
    go(0, 1'b0, 16'hFFFF, 16'h0001, 1'b0); wait_done(0, nb);
    go(0, 1'b0, 16'h7FFF, 16'h0001, 1'b0); wait_done(0, nb);

    // Start pulsed mid-RUN with new operands must be ignored; flags hold until done.
    go(0, 1'b1, 16'h1234, 16'h0234, 1'b0);
    @(negedge clk);
    chk("flags_hold_run", {29'h0, co[0], ovf[0], zero[0]}, 32'b010);
    start[0] = 1'b1; op = 1'b0; a = 16'hFFFF; b = 16'h0000;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, nb);

    // Start held high through RUN; operands switch during the FIN cycle.
    @(negedge clk);
    op = 1'b0; a = 16'h1111; b = 16'h2222; ci = 1'b1; start[0] = 1'b1;
    sbq.push_back(model(0, 1'b0, 16'h1111, 16'h2222, 1'b1, cyc + 1 + 5));
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (!busy[0]) ok = 1'b1;
    end
    if (!ok) chk("b2b_busy_timeout", 32'd0, 32'd1);
    op = 1'b1; a = 16'h0100; b = 16'h0200; ci = 1'b0;
    sbq.push_back(model(0, 1'b1, 16'h0100, 16'h0200, 1'b0, cyc + 1 + 5));
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    wait_done(0, nb);
    @(negedge clk);
    chk("b2b_done_spacing", 32'(last_done - prev_done), 32'd5);

    // Reset two cycles into RUN aborts the operation with no done.
    go(0, 1'b1, 16'h00F0, 16'h000F, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    sbq.delete(sbq.size() - 1);
    chk("async_rst_result", 32'(res16), 32'h0);
    chk("async_rst_ctrl_flags", {27'h0, busy[0], done[0], co[0], ovf[0], zero[0]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    go(0, 1'b1, 16'h0009, 16'h0006, 1'b0); wait_done(0, nb);

    for (int i = 0; i < 5; i++) begin
      go(1, 1'b1, sv_a[i], sv_b[i], 1'b0); wait_done(1, nb); chk("busy_cycles_n4", 32'(nb), 32'd1);
      go(2, 1'b1, sv_a[i], sv_b[i], 1'b0); wait_done(2, nb); chk("busy_cycles_n8", 32'(nb), 32'd4);
    end

    for (int i = 0; i < 12; i++) begin
      int id = i % 3;
      go(id, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      wait_done(id, nb);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
